// File: rtl/spie_engine.sv
// SPI mode-0 shift engine: serialises 8/16/32-bit words with selectable byte order
// and deserialises MISO into a receive word reordered to match the transmit layout.
module spie_engine #(
  parameter int clock_freq = 50_000_000,
  parameter int slow_freq  = 400_000,
  parameter int fast_freq  = 10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fast,
  input  logic [1:0]  datawidth,
  input  logic        msbytefirst,
  input  logic        start,
  input  logic [31:0] dataTx,
  output logic [31:0] dataRx,
  output logic        rdy,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);

  localparam int half_slow_raw = clock_freq / (2 * slow_freq);
  localparam int half_fast_raw = clock_freq / (2 * fast_freq);
  localparam int half_slow     = (half_slow_raw < 1) ? 1 : half_slow_raw;
  localparam int half_fast     = (half_fast_raw < 1) ? 1 : half_fast_raw;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] half_reg;
  logic [31:0] cnt_reg;
  logic [4:0]  bit_reg;
  logic [1:0]  width_reg;
  logic        msb_reg;
  logic [31:0] tx_reg;
  logic [31:0] rx_reg;
  logic [31:0] data_rx_reg;

  logic [4:0]  last_bit;
  logic        phase_end;
  logic [31:0] tx_load;
  logic [31:0] rx_word;

  assign phase_end = (cnt_reg == half_reg - 32'd1);

  always_comb begin
    last_bit = 5'd7;
    case (width_reg)
      2'b01:   last_bit = 5'd31;
      2'b10:   last_bit = 5'd15;
      default: last_bit = 5'd7;
    endcase
  end

  // The shift register always emits bit 31 first, so the word is pre-arranged
  // into wire order (first byte at the top) when the transfer is latched.
  always_comb begin
    tx_load = {dataTx[7:0], 24'd0};
    case (datawidth)
      2'b01: tx_load = msbytefirst ? dataTx
                       : {dataTx[7:0], dataTx[15:8], dataTx[23:16], dataTx[31:24]};
      2'b10: tx_load = msbytefirst ? {dataTx[15:0], 16'd0}
                       : {dataTx[7:0], dataTx[15:8], 16'd0};
      default: tx_load = {dataTx[7:0], 24'd0};
    endcase
  end

  // Received bits land in wire order (first byte highest); undo the byte order here.
  always_comb begin
    rx_word = {24'd0, rx_reg[7:0]};
    case (width_reg)
      2'b01: rx_word = msb_reg ? rx_reg
                       : {rx_reg[7:0], rx_reg[15:8], rx_reg[23:16], rx_reg[31:24]};
      2'b10: rx_word = msb_reg ? {16'd0, rx_reg[15:0]}
                       : {16'd0, rx_reg[7:0], rx_reg[15:8]};
      default: rx_word = {24'd0, rx_reg[7:0]};
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = LOW;
      LOW:  if (phase_end) state_next = HIGH;
      HIGH: if (phase_end) state_next = (bit_reg == last_bit) ? DONE : LOW;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      half_reg    <= 32'd0;
      cnt_reg     <= 32'd0;
      bit_reg     <= 5'd0;
      width_reg   <= 2'b00;
      msb_reg     <= 1'b0;
      tx_reg      <= 32'd0;
      rx_reg      <= 32'd0;
      data_rx_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            half_reg  <= fast ? 32'(half_fast) : 32'(half_slow);
            width_reg <= datawidth;
            msb_reg   <= msbytefirst;
            tx_reg    <= tx_load;
            rx_reg    <= 32'd0;
            bit_reg   <= 5'd0;
            cnt_reg   <= 32'd0;
          end
        end
        LOW: begin
          if (phase_end) begin
            cnt_reg <= 32'd0;
            rx_reg  <= {rx_reg[30:0], miso};
          end else begin
            cnt_reg <= cnt_reg + 32'd1;
          end
        end
        HIGH: begin
          if (phase_end) begin
            cnt_reg <= 32'd0;
            if (bit_reg != last_bit) begin
              bit_reg <= bit_reg + 5'd1;
              tx_reg  <= {tx_reg[30:0], 1'b0};
            end
          end else begin
            cnt_reg <= cnt_reg + 32'd1;
          end
        end
        DONE: data_rx_reg <= rx_word;
        default: ;
      endcase
    end
  end

  assign rdy    = (state_reg == IDLE);
  assign sclk   = (state_reg == HIGH);
  assign mosi   = (state_reg == LOW || state_reg == HIGH) ? tx_reg[31] : 1'b1;
  assign dataRx = data_rx_reg;

endmodule
